// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a block-read/write main memory.
// Define MEM_ARB_ROUNDROBIN_EN for round-robin on simultaneous requests; default is fixed D priority.
module mem_arbiter #(
  parameter int blocksize = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      IReq,
  input  logic [31:0]               IAdr,
  output logic [blocksize*32-1:0]   IRd,
  output logic                      IValid,
  input  logic                      DReq,
  input  logic                      DWe,
  input  logic [31:0]               DAdr,
  input  logic [blocksize*32-1:0]   DWd,
  output logic [blocksize*32-1:0]   DRd,
  output logic                      DValid,
  output logic                      MemRE,
  output logic                      MemWE,
  output logic [31:0]               MemAdr,
  output logic [blocksize*32-1:0]   MemWD,
  input  logic [blocksize*32-1:0]   MemRd,
  input  logic                      MemValid,
  output logic                      Busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IGRANT  = 2'd1,
    DGRANT  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [31:0]               adr_q, adr_d;
  logic [blocksize*32-1:0]   wd_q, wd_d;
  logic                      we_q, we_d;
  logic [blocksize*32-1:0]   ird_q, ird_d;
  logic [blocksize*32-1:0]   drd_q, drd_d;
  logic                      ivalid_q, ivalid_d;
  logic                      dvalid_q, dvalid_d;
  logic                      memre_q, memre_d;
  logic                      memwe_q, memwe_d;
  logic                      busy_q, busy_d;
  logic                      d_wins_s;

`ifdef MEM_ARB_ROUNDROBIN_EN
  // 1 = last grant went to D, so I wins the next tie; reset favours I.
  logic                      last_d_q, last_d_d;
`endif

  // Arbitration, capture, completion handling and registered output values
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    wd_d     = wd_q;
    we_d     = we_q;
    ird_d    = ird_q;
    drd_d    = drd_q;
    ivalid_d = 1'b0;
    dvalid_d = 1'b0;
`ifdef MEM_ARB_ROUNDROBIN_EN
    last_d_d = last_d_q;
    d_wins_s = DReq && (!IReq || !last_d_q);
`else
    d_wins_s = DReq;
`endif

    case (state_q)
      IDLE: begin
        if (d_wins_s) begin
          state_d = DGRANT;
          adr_d   = DAdr;
          wd_d    = DWd;
          we_d    = DWe;
`ifdef MEM_ARB_ROUNDROBIN_EN
          last_d_d = 1'b1;
`endif
        end else if (IReq) begin
          state_d = IGRANT;
          adr_d   = IAdr;
          we_d    = 1'b0;
`ifdef MEM_ARB_ROUNDROBIN_EN
          last_d_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      IGRANT: begin
        if (MemValid) begin
          ird_d    = MemRd;
          ivalid_d = 1'b1;
          state_d  = RELEASE;
        end else begin
          state_d  = IGRANT;
        end
      end
      DGRANT: begin
        if (MemValid) begin
          if (!we_q) begin
            drd_d = MemRd;
          end else begin
            drd_d = drd_q;
          end
          dvalid_d = 1'b1;
          state_d  = RELEASE;
        end else begin
          state_d  = DGRANT;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    memre_d = (state_d == IGRANT) || ((state_d == DGRANT) && !we_d);
    memwe_d = (state_d == DGRANT) && we_d;
    busy_d  = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      adr_q    <= 32'd0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      ird_q    <= '0;
      drd_q    <= '0;
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      memre_q  <= 1'b0;
      memwe_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      wd_q     <= wd_d;
      we_q     <= we_d;
      ird_q    <= ird_d;
      drd_q    <= drd_d;
      ivalid_q <= ivalid_d;
      dvalid_q <= dvalid_d;
      memre_q  <= memre_d;
      memwe_q  <= memwe_d;
      busy_q   <= busy_d;
    end
  end

`ifdef MEM_ARB_ROUNDROBIN_EN
  // Round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`endif

  assign IRd    = ird_q;
  assign IValid = ivalid_q;
  assign DRd    = drd_q;
  assign DValid = dvalid_q;
  assign MemRE  = memre_q;
  assign MemWE  = memwe_q;
  assign MemAdr = adr_q;
  assign MemWD  = wd_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the memory is played inline by the serve task.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int BW = 128;

  logic          clk;
  logic          reset;
  logic          IReq;
  logic [31:0]   IAdr;
  logic [BW-1:0] IRd;
  logic          IValid;
  logic          DReq;
  logic          DWe;
  logic [31:0]   DAdr;
  logic [BW-1:0] DWd;
  logic [BW-1:0] DRd;
  logic          DValid;
  logic          MemRE;
  logic          MemWE;
  logic [31:0]   MemAdr;
  logic [BW-1:0] MemWD;
  logic [BW-1:0] MemRd;
  logic          MemValid;
  logic          Busy;

  int checks_cnt = 0;
  int errors_cnt = 0;

  mem_arbiter #(.blocksize(4)) dut (
    .clk(clk), .reset(reset),
    .IReq(IReq), .IAdr(IAdr), .IRd(IRd), .IValid(IValid),
    .DReq(DReq), .DWe(DWe), .DAdr(DAdr), .DWd(DWd), .DRd(DRd), .DValid(DValid),
    .MemRE(MemRE), .MemWE(MemWE), .MemAdr(MemAdr), .MemWD(MemWD),
    .MemRd(MemRd), .MemValid(MemValid), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a grant, hold the memory busy for 'waits' cycles, then complete.
  // Returns in the RELEASE cycle with the granted address.
  task automatic serve(input int waits, input logic [BW-1:0] rd, output logic [31:0] adr);
    int n;
    n = 0;
    while (!(MemRE || MemWE) && n < 20) begin
      tick();
      n++;
    end
    adr = MemAdr;
    if (!(MemRE || MemWE)) begin
      check_value("grant_timeout", 128'd0, 128'd1);
    end else begin
      repeat (waits) begin
        tick();
        check_value("mem_en_held", {127'd0, MemRE | MemWE}, 128'd1);
      end
      MemValid = 1'b1;
      MemRd    = rd;
      tick();
      MemValid = 1'b0;
      MemRd    = '0;
    end
  endtask

  logic [BW-1:0] blk_a, blk_b, blk_w, blk_x;
  logic [31:0]   gadr;
  logic [31:0]   exp_order [4];

  initial begin
    blk_a = {32'hAAAA0004, 32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001};
    blk_b = {32'hBBBB0004, 32'hBBBB0003, 32'hBBBB0002, 32'hBBBB0001};
    blk_w = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    blk_x = {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
`ifdef MEM_ARB_ROUNDROBIN_EN
    exp_order[0] = 32'h500; exp_order[1] = 32'h600;
    exp_order[2] = 32'h500; exp_order[3] = 32'h600;
`else
    exp_order[0] = 32'h600; exp_order[1] = 32'h600;
    exp_order[2] = 32'h600; exp_order[3] = 32'h600;
`endif

    reset = 1'b1; IReq = 1'b1; IAdr = 32'h40;
    DReq = 1'b0; DWe = 1'b0; DAdr = 32'd0; DWd = '0;
    MemRd = '0; MemValid = 1'b0;

    // Reset with IReq held
    tick(); tick();
    check_value("rst_memre", {127'd0, MemRE}, 128'd0);
    check_value("rst_ivalid", {127'd0, IValid}, 128'd0);
    check_value("rst_busy", {127'd0, Busy}, 128'd0);
    check_value("rst_memadr", {96'd0, MemAdr}, 128'd0);
    check_value("rst_ird", IRd, 128'd0);
    check_value("rst_drd", DRd, 128'd0);
    reset = 1'b0;
    tick();
    check_value("first_grant_re", {127'd0, MemRE}, 128'd1);
    check_value("first_grant_adr", {96'd0, MemAdr}, 128'h40);
    check_value("first_grant_busy", {127'd0, Busy}, 128'd1);
    serve(0, blk_b, gadr);
    IReq = 1'b0;
    check_value("first_ivalid", {127'd0, IValid}, 128'd1);
    tick();

    // I read of 0x100
    IReq = 1'b1; IAdr = 32'h100;
    serve(2, blk_a, gadr);
    IReq = 1'b0;
    check_value("iread_adr", {96'd0, gadr}, 128'h100);
    check_value("iread_ivalid", {127'd0, IValid}, 128'd1);
    check_value("iread_ird", IRd, blk_a);
    check_value("iread_release_re", {127'd0, MemRE}, 128'd0);
    check_value("iread_dvalid", {127'd0, DValid}, 128'd0);
    tick();
    check_value("iread_ivalid_drop", {127'd0, IValid}, 128'd0);
    check_value("iread_idle_busy", {127'd0, Busy}, 128'd0);

    // IAdr changed mid-grant
    IReq = 1'b1; IAdr = 32'h300;
    tick();
    IAdr = 32'h400;
    tick();
    check_value("iadr_hold", {96'd0, MemAdr}, 128'h300);
    serve(0, blk_a, gadr);
    IReq = 1'b0;
    tick();

    // D read of 0x180, then D write of 0x200
    DReq = 1'b1; DWe = 1'b0; DAdr = 32'h180;
    serve(1, blk_b, gadr);
    DReq = 1'b0;
    check_value("dread_dvalid", {127'd0, DValid}, 128'd1);
    check_value("dread_drd", DRd, blk_b);
    check_value("dread_ivalid", {127'd0, IValid}, 128'd0);
    tick();
    DReq = 1'b1; DWe = 1'b1; DAdr = 32'h200; DWd = blk_w;
    tick();
    check_value("dwrite_we", {127'd0, MemWE}, 128'd1);
    check_value("dwrite_re", {127'd0, MemRE}, 128'd0);
    check_value("dwrite_adr", {96'd0, MemAdr}, 128'h200);
    check_value("dwrite_wd", MemWD, blk_w);
    DWd = '0;
    serve(1, blk_x, gadr);
    DReq = 1'b0;
    check_value("dwrite_dvalid", {127'd0, DValid}, 128'd1);
    check_value("dwrite_drd_kept", DRd, blk_b);
    check_value("dwrite_release_we", {127'd0, MemWE}, 128'd0);
    tick();
    DWe = 1'b0;

    // Both requesting, back-to-back
    IReq = 1'b1; IAdr = 32'h500; DReq = 1'b1; DAdr = 32'h600;
    for (int i = 0; i < 4; i++) begin
      serve(1, blk_a, gadr);
      check_value($sformatf("order_%0d", i), {96'd0, gadr}, {96'd0, exp_order[i]});
      check_value($sformatf("valid_owner_%0d", i), {126'd0, IValid, DValid},
                  (exp_order[i] == 32'h500) ? 128'd2 : 128'd1);
    end
    IReq = 1'b0; DReq = 1'b0;
    tick();
    tick();
    check_value("b2b_idle", {127'd0, Busy}, 128'd0);

    // Reset during DGRANT, then stray MemValid
    DReq = 1'b1; DWe = 1'b0; DAdr = 32'h700;
    tick();
    check_value("dgrant_re", {127'd0, MemRE}, 128'd1);
    reset = 1'b1;
    #1;
    check_value("midrst_busy", {127'd0, Busy}, 128'd0);
    check_value("midrst_re", {127'd0, MemRE}, 128'd0);
    check_value("midrst_drd", DRd, 128'd0);
    tick();
    reset = 1'b0; DReq = 1'b0;
    MemValid = 1'b1; MemRd = blk_x;
    tick();
    MemValid = 1'b0; MemRd = '0;
    check_value("stray_dvalid", {127'd0, DValid}, 128'd0);
    check_value("stray_drd", DRd, 128'd0);
    check_value("stray_busy", {127'd0, Busy}, 128'd0);
    tick();
    check_value("stray_dvalid_late", {127'd0, DValid}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single block-read/write simulated main memory between the instruction-cache refill port (I) and the data-cache refill/writeback port (D).
- Grants one requester at a time and holds that grant until the memory reports `MemValid`.
- Registers the returned block and pulses a one-cycle valid to the owning requester.
- Sits between both caches and the memory model; neither cache drives memory directly.

## Interface
- `blocksize`, 4: words per cache block; all block buses are `blocksize*32` bits.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `IReq`  in  1  I-side block read request; held high until `IValid`.
- `IAdr`  in  32  I-side block address; stable while `IReq`.
- `IRd`  out  blocksize*32  registered block returned to I-side.
- `IValid`  out  1  one-cycle pulse, `IRd` valid.
- `DReq`  in  1  D-side request; held high until `DValid`.
- `DWe`  in  1  D-side write (1) / read (0); stable while `DReq`.
- `DAdr`  in  32  D-side block address.
- `DWd`  in  blocksize*32  D-side write block.
- `DRd`  out  blocksize*32  registered block returned to D-side; unchanged on writes.
- `DValid`  out  1  one-cycle pulse: D read data valid or write done.
- `MemRE`  out  1  memory read enable.
- `MemWE`  out  1  memory write enable.
- `MemAdr`  out  32  captured address of the granted request.
- `MemWD`  out  blocksize*32  captured write block.
- `MemRd`  in  blocksize*32  memory read block.
- `MemValid`  in  1  memory completion, high for one cycle.
- `Busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, IGRANT, DGRANT, RELEASE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: winner chosen per Configuration.
  - On grant, capture address (and for D: `DWe`, `DWd`) into registers.
- IGRANT: `MemRE`=1, `MemWE`=0, `MemAdr`=captured I address.
- DGRANT: `MemRE`=~we, `MemWE`=we, `MemAdr`/`MemWD` from captured D registers.
- Leaving a grant state:
  - Stay until `MemValid`=1.
  - On `MemValid`, register `MemRd` into `IRd`/`DRd` (skipped on D write), then go to RELEASE.
- RELEASE:
  - `MemRE`=`MemWE`=0 for exactly one cycle, so the memory returns to idle without seeing a new request.
  - Owning valid (`IValid` or `DValid`) is high in this cycle only.
  - Next state is IDLE.
- Requester changes to `IAdr`/`DAdr`/`DWd` after grant are ignored (captured values used).
- `MemValid` in IDLE or RELEASE: ignored, no output change.
- A requester keeping `Req` high in its valid cycle is treated as a new request, re-arbitrated in the following IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `MemRE`, `MemWE`, `IValid`, `DValid`, `Busy` = 0.
  - `MemAdr`, `MemWD`, `IRd`, `DRd` = 0.
  - Round-robin pointer favours I.
- Reset mid-transaction: immediate return to IDLE and all outputs to reset values. In-flight memory completion is dropped by the IDLE rule. The system resets memory concurrently.
- Latency:
  - Req sampled in IDLE at edge k.
  - `MemRE`/`MemWE` high from k to the edge where `MemValid` is sampled (m).
  - Valid pulse and data appear between edges m and m+1.
  - Earliest next grant is sampled at m+2.
- Arbiter overhead: 1 cycle (grant) + 1 cycle (RELEASE) beyond memory latency. A memory wait of `W` gives Req-to-Valid = `W`+3 cycles.
- `IValid` and `DValid` are never high together. `MemRE` and `MemWE` are never high together.

## Configuration
- `MEM_ARB_ROUNDROBIN_EN` defined:
  - One-bit pointer records the last granted side.
  - On simultaneous requests, the other side wins.
  - Pointer updates only on grant.
- Undefined: fixed priority, D always wins simultaneous requests, no pointer register.

## Test plan
- Reset with `IReq`=1 held, then release → after reset `MemRE`=0 and `IValid`=0; first grant sampled at the first post-reset edge, `MemAdr`=`IAdr`=0x00000040.
- I read of 0x100 with memory returning 0xAAAA…_0001..0004 → `IRd` equals that block, `IValid` one cycle, `MemRE` low in the RELEASE cycle.
- D write to 0x200 with `DWd`=0x1111…4444 → `MemWE`=1, `MemWD` matches, `DValid` pulses, `DRd` unchanged.
- `IReq` and `DReq` both high, back-to-back for 4 transactions:
  - With `MEM_ARB_ROUNDROBIN_EN`: grant order I, D, I, D.
  - Without: D, D, D, D while `DReq` is re-asserted.
- `IAdr` changed from 0x300 to 0x400 mid-grant → `MemAdr` stays 0x300.
- `reset` pulsed while in DGRANT, then stray `MemValid` one cycle later → state IDLE, `DValid`=0, `DRd`=0.
